// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings, issue-controller states and default width.
// Imported by the issue controller, its register file and the ALU top-level bench.
package alu_pkg;

    localparam int DEFAULT_N = 32;

    localparam logic [2:0] OP_0    = 3'b000;
    localparam logic [2:0] OP_1    = 3'b001;
    localparam logic [2:0] OP_2    = 3'b010;
    localparam logic [2:0] OP_3    = 3'b011;
    localparam logic [2:0] OP_4    = 3'b100;
    localparam logic [2:0] OP_5    = 3'b101;
    localparam logic [2:0] OP_ILL6 = 3'b110;
    localparam logic [2:0] OP_ILL7 = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_WB,
        S_ERR
    } ctrlState_e;

    function automatic logic isLegalOp(input logic [2:0] op);
        return op <= OP_5;
    endfunction

endpackage

// File: rtl/alu_regfile.sv
// Register file for the ALU issue controller: WB-priority write arbitration,
// two combinational operand snapshot ports and a registered host read port.
module alu_regfile
    import alu_pkg::*;
#(
    parameter int N    = DEFAULT_N,
    parameter int REGS = 8,
    localparam int AW  = $clog2(REGS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          hostWe,
    input  logic [AW-1:0] hostAddr,
    input  logic [N-1:0]  hostData,
    input  logic          wbWe,
    input  logic [AW-1:0] wbAddr,
    input  logic [N-1:0]  wbData,
    input  logic [AW-1:0] rdAddrA,
    output logic [N-1:0]  rdDataA,
    input  logic [AW-1:0] rdAddrB,
    output logic [N-1:0]  rdDataB,
    input  logic [AW-1:0] hostRdAddr,
    output logic [N-1:0]  hostRdData
);

    logic [N-1:0] regs [REGS];

    logic hostCollides;
    assign hostCollides = wbWe && (wbAddr == hostAddr);

    assign rdDataA = regs[rdAddrA];
    assign rdDataB = regs[rdAddrB];

    // NOTE: the array is reset explicitly because a post-reset read must return 0;
    // this keeps it in flops rather than a RAM macro, acceptable at this depth.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < REGS; i++) begin
                regs[i] <= '0;
            end
            hostRdData <= '0;
        end else begin
            // NOTE: non-blocking here gives read-before-write on hostRdData for free.
            if (hostWe && !hostCollides) begin
                regs[hostAddr] <= hostData;
            end
            if (wbWe) begin
                regs[wbAddr] <= wbData;
            end
            hostRdData <= regs[hostRdAddr];
        end
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Operand-issue and writeback controller in front of the 32-bit structural ALU:
// accepts one instruction at a time, drives op/R2/R3, waits ALU_LAT, writes R0 back.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int N       = DEFAULT_N,
    parameter int REGS    = 8,
    parameter int ALU_LAT = 1,
    localparam int AW     = $clog2(REGS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          instr_valid,
    output logic          instr_ready,
    input  logic [2:0]    instr_op,
    input  logic [AW-1:0] instr_dst,
    input  logic [AW-1:0] instr_src_a,
    input  logic [AW-1:0] instr_src_b,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [N-1:0]  wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [N-1:0]  rd_data,
    output logic [2:0]    alu_op,
    output logic [N-1:0]  alu_a,
    output logic [N-1:0]  alu_b,
    input  logic [N-1:0]  alu_result,
    output logic          done,
    output logic          done_err,
    output logic [AW-1:0] done_dst,
    output logic [N-1:0]  done_data
);

    ctrlState_e    state;
    ctrlState_e    stateNext;
    logic [3:0]    waitCnt;
    logic [2:0]    snapOp;
    logic [N-1:0]  snapA;
    logic [N-1:0]  snapB;
    logic [AW-1:0] snapDst;
    logic [N-1:0]  resultQ;
    logic [N-1:0]  srcAData;
    logic [N-1:0]  srcBData;
    logic          wbWe;
    logic          lastWait;

    assign instr_ready = (state == S_IDLE) && !rst;
    assign wbWe        = (state == S_WB);
    assign lastWait    = (waitCnt == 4'd1);

    alu_regfile #(
        .N    (N),
        .REGS (REGS)
    ) u_regfile (
        .clk        (clk),
        .rst        (rst),
        .hostWe     (wr_en),
        .hostAddr   (wr_addr),
        .hostData   (wr_data),
        .wbWe       (wbWe),
        .wbAddr     (snapDst),
        .wbData     (resultQ),
        .rdAddrA    (instr_src_a),
        .rdDataA    (srcAData),
        .rdAddrB    (instr_src_b),
        .rdDataB    (srcBData),
        .hostRdAddr (rd_addr),
        .hostRdData (rd_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // NOTE: stateNext is defaulted before the case so no path leaves it unassigned (no latch).
    always_comb begin
        stateNext = state;
        case (state)
            S_IDLE:  if (instr_valid) stateNext = isLegalOp(instr_op) ? S_ISSUE : S_ERR;
            S_ISSUE: stateNext = S_WAIT;
            S_WAIT:  if (lastWait) stateNext = S_WB;
            S_WB:    stateNext = S_IDLE;
            S_ERR:   stateNext = S_IDLE;
            default: stateNext = S_IDLE;
        endcase
    end

    // ALU drive registers change only in ISSUE, so R2/R3/op never glitch between operations.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            waitCnt   <= '0;
            snapOp    <= '0;
            snapA     <= '0;
            snapB     <= '0;
            snapDst   <= '0;
            resultQ   <= '0;
            alu_op    <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            done      <= 1'b0;
            done_err  <= 1'b0;
            done_dst  <= '0;
            done_data <= '0;
        end else begin
            done     <= 1'b0;
            done_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (instr_valid && isLegalOp(instr_op)) begin
                        snapOp  <= instr_op;
                        snapA   <= srcAData;
                        snapB   <= srcBData;
                        snapDst <= instr_dst;
                    end
                end
                S_ISSUE: begin
                    alu_op  <= snapOp;
                    alu_a   <= snapA;
                    alu_b   <= snapB;
                    waitCnt <= 4'(ALU_LAT);
                end
                S_WAIT: begin
                    waitCnt <= waitCnt - 4'd1;
                    if (lastWait) begin
                        resultQ <= alu_result;
                    end
                end
                S_WB: begin
                    done      <= 1'b1;
                    done_dst  <= snapDst;
                    done_data <= resultQ;
                end
                S_ERR: begin
                    done     <= 1'b1;
                    done_err <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl: directed instructions push expected completions,
// a negedge monitor pops and compares them whenever done is presented.
module tb_alu_issue_ctrl;

    localparam int N    = 32;
    localparam int REGS = 8;
    localparam int LAT  = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic        instr_ready;
    logic [2:0]  instr_op;
    logic [2:0]  instr_dst;
    logic [2:0]  instr_src_a;
    logic [2:0]  instr_src_b;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [31:0] wr_data;
    logic [2:0]  rd_addr;
    logic [31:0] rd_data;
    logic [2:0]  alu_op;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [31:0] alu_result;
    logic        done;
    logic        done_err;
    logic [2:0]  done_dst;
    logic [31:0] done_data;

    typedef struct {
        logic        err;
        logic [2:0]  dst;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t        sbQ[$];
    logic [31:0] model [REGS];
    logic [2:0]  lastDst;
    logic [31:0] lastData;
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;

    alu_issue_ctrl #(.N(N), .REGS(REGS), .ALU_LAT(LAT)) dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr_op    (instr_op),
        .instr_dst   (instr_dst),
        .instr_src_a (instr_src_a),
        .instr_src_b (instr_src_b),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .alu_op      (alu_op),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_result  (alu_result),
        .done        (done),
        .done_err    (done_err),
        .done_dst    (done_dst),
        .done_data   (done_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural stand-in for the structural ALU (010 = add).
    function automatic logic [31:0] aluModel(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            3'b000:  return a & b;
            3'b001:  return a | b;
            3'b010:  return a + b;
            3'b011:  return a ^ (b << 1);
            3'b100:  return a ^ b;
            3'b101:  return ~(a | b);
            default: return 32'h0;
        endcase
    endfunction

    always_comb alu_result = aluModel(alu_op, alu_a, alu_b);

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && done) begin
            if (sbQ.size() == 0) begin
                check("spurious_done", done, 1'b0);
            end else begin
                exp_t e;
                e = sbQ.pop_front();
                check("done_err", done_err, e.err);
                check("done_dst", done_dst, e.dst);
                check("done_data", done_data, e.data);
                check("done_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic hostWrite(input logic [2:0] a, input logic [31:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
        model[a] = d;
    endtask

    task automatic readReg(input string name, input logic [2:0] a, input logic [31:0] exp);
        rd_addr = a;
        @(negedge clk);
        check(name, rd_data, exp);
    endtask

    // Offers one instruction; returns at the negedge after the accepting edge.
    task automatic issue(input logic [2:0] op, input logic [2:0] dst, input logic [2:0] sa,
                         input logic [2:0] sb, input bit hold, input bit track,
                         output int accCyc, output int waitN);
        logic [31:0] res;
        instr_valid = 1'b1; instr_op = op; instr_dst = dst;
        instr_src_a = sa; instr_src_b = sb;
        waitN = 0;
        while (!instr_ready && waitN < 100) begin
            @(negedge clk);
            waitN++;
        end
        check("accept_timeout", instr_ready, 1'b1);
        @(posedge clk);
        @(negedge clk);
        accCyc = cyc;
        if (!hold) instr_valid = 1'b0;
        if (track) begin
            if (op > 3'b101) begin
                sbQ.push_back('{1'b1, lastDst, lastData, accCyc + 1});
            end else begin
                res = aluModel(op, model[sa], model[sb]);
                sbQ.push_back('{1'b0, dst, res, accCyc + LAT + 2});
                model[dst] = res;
                lastDst = dst;
                lastData = res;
            end
        end
    endtask

    task automatic drain();
        int n = 0;
        while (sbQ.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", sbQ.size(), 0);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int acc1, acc2, w1, w2;
        logic [2:0]  prevOp;
        logic [31:0] prevA, prevB;
        logic [31:0] snapVal;

        rst = 1'b1; instr_valid = 1'b0; instr_op = '0; instr_dst = '0;
        instr_src_a = '0; instr_src_b = '0; wr_en = 1'b0; wr_addr = '0;
        wr_data = '0; rd_addr = '0;
        for (int i = 0; i < REGS; i++) model[i] = '0;
        lastDst = '0; lastData = '0;

        repeat (2) @(negedge clk);
        check("rst_ready", instr_ready, 1'b0);
        check("rst_alu_op", alu_op, 3'd0);
        check("rst_alu_a", alu_a, 32'd0);
        check("rst_alu_b", alu_b, 32'd0);
        check("rst_done", {done, done_err}, 2'b00);
        check("rst_done_dst", done_dst, 3'd0);
        check("rst_done_data", done_data, 32'd0);
        check("rst_rd_data", rd_data, 32'd0);
        rst = 1'b0;
        #1 check("ready_after_rst", instr_ready, 1'b1);
        @(negedge clk);

        // Basic add: 13 + 15 = 28 into r3.
        hostWrite(3'd1, 32'd13);
        hostWrite(3'd2, 32'd15);
        issue(3'b010, 3'd3, 3'd1, 3'd2, 1'b0, 1'b1, acc1, w1);
        drain();
        readReg("rd_r3_add", 3'd3, 32'd28);

        // Back-to-back with valid held: 13 & 15 = 13, then 28 | 13 = 29.
        issue(3'b000, 3'd4, 3'd1, 3'd2, 1'b1, 1'b1, acc1, w1);
        issue(3'b001, 3'd5, 3'd3, 3'd1, 1'b0, 1'b1, acc2, w2);
        check("b2b_spacing", acc2 - acc1, LAT + 3);
        check("b2b_ready_low", w2, LAT + 2);
        drain();
        readReg("rd_r4_and", 3'd4, 32'd13);
        readReg("rd_r5_or", 3'd5, 32'd29);

        // Illegal opcode: error pulse, ALU inputs and registers untouched.
        prevOp = alu_op; prevA = alu_a; prevB = alu_b;
        issue(3'b110, 3'd3, 3'd1, 3'd2, 1'b0, 1'b1, acc1, w1);
        drain();
        check("ill_alu_op", alu_op, prevOp);
        check("ill_alu_a", alu_a, prevA);
        check("ill_alu_b", alu_b, prevB);
        readReg("ill_r3", 3'd3, 32'd28);

        // Snapshot: host overwrites r1 while the op is in WAIT.
        hostWrite(3'd1, 32'd1794509151);
        issue(3'b011, 3'd6, 3'd1, 3'd1, 1'b0, 1'b1, acc1, w1);
        snapVal = model[6];
        @(negedge clk);
        check("snap_alu_a_wait", alu_a, 32'd1794509151);
        check("snap_alu_b_wait", alu_b, 32'd1794509151);
        wr_en = 1'b1; wr_addr = 3'd1; wr_data = 32'd0;
        @(negedge clk);
        wr_en = 1'b0;
        model[1] = 32'd0;
        check("snap_alu_a_wb", alu_a, 32'd1794509151);
        check("snap_alu_b_wb", alu_b, 32'd1794509151);
        drain();
        readReg("snap_r6", 3'd6, snapVal);
        readReg("snap_r1", 3'd1, 32'd0);

        // Host write colliding with WB on r3: WB wins (15 + 15 = 30).
        issue(3'b010, 3'd3, 3'd2, 3'd2, 1'b0, 1'b1, acc1, w1);
        repeat (LAT + 1) @(negedge clk);
        wr_en = 1'b1; wr_addr = 3'd3; wr_data = 32'hDEAD_BEEF;
        @(negedge clk);
        wr_en = 1'b0;
        drain();
        readReg("coll_r3", 3'd3, 32'd30);

        // Host write to r4 during WB to r3: both land (15 ^ 0 = 15).
        issue(3'b100, 3'd3, 3'd2, 3'd1, 1'b0, 1'b1, acc1, w1);
        repeat (LAT + 1) @(negedge clk);
        wr_en = 1'b1; wr_addr = 3'd4; wr_data = 32'h1234_5678;
        @(negedge clk);
        wr_en = 1'b0;
        model[4] = 32'h1234_5678;
        drain();
        readReg("par_r3", 3'd3, 32'd15);
        readReg("par_r4", 3'd4, 32'h1234_5678);

        // Result truncated to N bits, and NOR into r0.
        hostWrite(3'd5, 32'hFFFF_FFFF);
        hostWrite(3'd6, 32'd2);
        issue(3'b010, 3'd7, 3'd5, 3'd6, 1'b0, 1'b1, acc1, w1);
        issue(3'b101, 3'd0, 3'd5, 3'd6, 1'b0, 1'b1, acc2, w2);
        drain();
        readReg("wrap_r7", 3'd7, 32'd1);
        readReg("nor_r0", 3'd0, 32'd0);

        // Read-before-write on the host port.
        wr_en = 1'b1; wr_addr = 3'd7; wr_data = 32'd99; rd_addr = 3'd7;
        @(negedge clk);
        wr_en = 1'b0;
        check("rbw_old", rd_data, 32'd1);
        @(negedge clk);
        check("rbw_new", rd_data, 32'd99);

        // Reset during WAIT aborts the operation.
        issue(3'b010, 3'd2, 3'd7, 3'd7, 1'b0, 1'b0, acc1, w1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid_rst_ready", instr_ready, 1'b0);
        check("mid_rst_alu", {alu_op, alu_a, alu_b} == '0, 1'b1);
        check("mid_rst_done", {done, done_err}, 2'b00);
        check("mid_rst_done_val", {done_dst, done_data} == '0, 1'b1);
        check("mid_rst_rd", rd_data, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < REGS; i++) model[i] = '0;
        lastDst = '0; lastData = '0;
        #1 check("mid_rst_ready_after", instr_ready, 1'b1);
        @(negedge clk);
        for (int i = 0; i < REGS; i++) begin
            readReg("mid_rst_reg", 3'(i), 32'd0);
        end

        // Operation resumes after reset: 7 + 7 = 14.
        hostWrite(3'd1, 32'd7);
        issue(3'b010, 3'd2, 3'd1, 3'd1, 1'b0, 1'b1, acc1, w1);
        drain();
        readReg("resume_r2", 3'd2, 32'd14);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_issue_ctrl.md
# alu_issue_ctrl

Operand-issue and writeback controller sitting directly upstream of the 32-bit structural ALU top level. Holds a small register file, accepts one instruction at a time over a valid/ready handshake, and drives the ALU `op`/`R2`/`R3` inputs from snapshot operands. After a fixed ALU latency it captures the ALU `R0` result, writes it back to the destination register and reports completion. A host write port preloads registers and a registered read port exposes them.

## Interface
- `N`, 32: datapath width; matches the ALU operand and result width.
- `REGS`, 8: number of registers. Power of two; address width is `AW = log2(REGS)`.
- `ALU_LAT`, 1: cycles from operands/op stable at ALU inputs to `R0` valid. Legal range is 1–15.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `instr_valid` in 1: instruction offered.
- `instr_ready` out 1: controller can accept an instruction.
- `instr_op` in 3: ALU opcode. Codes 000–101 are legal; 110 and 111 are illegal.
- `instr_dst`, `instr_src_a`, `instr_src_b` in AW: register addresses.
- `wr_en` in 1, `wr_addr` in AW, `wr_data` in N: host register write.
- `rd_addr` in AW, `rd_data` out N: registered read, one-cycle latency.
- `alu_op` out 3: connects to ALU `op`.
- `alu_a` out N: connects to ALU `R2`.
- `alu_b` out N: connects to ALU `R3`.
- `alu_result` in N: from ALU `R0`.
- `done` out 1: one-cycle completion pulse.
- `done_err` out 1: qualifies `done`; 1 means an illegal opcode was dropped.
- `done_dst` out AW, `done_data` out N: writeback address and value. Both are held until the next `done`.

## Operation
- States:
  - IDLE: `instr_ready`=1. On `instr_valid` with a legal op, snapshot regfile[src_a], regfile[src_b], op and dst, then go to ISSUE. On an illegal op, go to ERR.
  - ISSUE: drive `alu_op`/`alu_a`/`alu_b` from the snapshot, load the wait counter with `ALU_LAT`, go to WAIT.
  - WAIT: decrement the counter each cycle. When it reaches 0, sample `alu_result`, go to WB.
  - WB: write regfile[dst], pulse `done`=1 with `done_err`=0, update `done_dst`/`done_data`, return to IDLE.
  - ERR: pulse `done`=1 with `done_err`=1. No ALU drive change, no writeback. `done_dst`/`done_data` are unchanged. Return to IDLE.
- `alu_op`/`alu_a`/`alu_b` hold their last issued values outside ISSUE/WAIT, so the ALU inputs never glitch.
- Operands are snapshotted at accept. Host writes after accept do not affect an in-flight operation.
- Source equal to destination is legal. The old value is used as the operand.
- Host write and WB to the same address in the same cycle: WB wins and the host write is dropped. Different addresses: both are committed.
- Read during a write to the same address returns the old value (read-before-write).
- No width growth. The result is exactly N bits as produced by the ALU; there is no carry/overflow output.

## Timing
- Reset, asynchronous: state=IDLE, all registers=0, `alu_op`=0, `alu_a`=0, `alu_b`=0, `done`=0, `done_err`=0, `done_dst`=0, `done_data`=0, `rd_data`=0, `instr_ready`=0 while `rst`=1.
- `instr_ready` = (state==IDLE) & ~`rst`. It is 1 in the first cycle after `rst` falls.
- Accept at edge 0. ALU inputs are valid after edge 1. `alu_result` is sampled at edge 1+`ALU_LAT`. `done` is high in the cycle after edge 2+`ALU_LAT`.
- Legal-op accept-to-`done` latency is `ALU_LAT`+2 cycles. Illegal-op latency is 1 cycle.
- Maximum throughput is one instruction per `ALU_LAT`+3 cycles, because the next accept is possible in the cycle after WB.
- `rst` mid-operation aborts the instruction: no writeback, no `done`.

## Structure
- Shared package `alu_pkg` holds:
  - opcode localparams: `OP_0`..`OP_5`, with illegal opcodes 110/111.
  - the state encoding: IDLE, ISSUE, WAIT, WB, ERR.
  - the default `N`.
- The ALU top-level test bench also imports `alu_pkg`.
- One sub-module: `alu_regfile`. It has the REGS×N array, the host/WB write arbitration with WB priority, two combinational snapshot read ports, and the registered host read port.

## Test plan
- Reset, then `wr` r1=13 and r2=15, then issue op=010 with dst=r3, a=r1, b=r2, using a behavioural ALU model (010 = add) on `alu_result`. Required: `done` at accept+`ALU_LAT`+2, `done_data`=28, `done_dst`=3, and `rd_addr`=3 returns 28.
- Back-to-back issue with `instr_valid` held high. Required: `instr_ready` is low during ISSUE/WAIT/WB, and the second accept occurs exactly `ALU_LAT`+3 cycles after the first.
- Issue op=110. Required: `done`=1 and `done_err`=1 one cycle later, no register changes, and `alu_op` unchanged.
- Issue op=011 with a=r1=1,794,509,151 and b=r1. During WAIT, host-write r1=0. Required: `alu_a`=`alu_b`=1,794,509,151 throughout, and the WB result matches the model for the old operands.
- Host `wr_en` to r3 in the same cycle as WB to r3. Required: r3 holds the ALU result. Host write to r4 in the same cycle: r4 is updated.
- Assert `rst` during WAIT. Required: all outputs 0 immediately, no `done`, registers 0, and `instr_ready`=1 the cycle after release.
